// File: rtl/sync_queue_pkg.sv
// Shared queue definitions: default geometry, pointer width and a constant clog2 helper.
// Used by sync_queue and queue_mem; the dual-clock queue imports the same package.
package sync_queue_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_DEPTH_LOG2 = 2;

  // Pointers carry one wrap bit above the storage index.
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

  function automatic int clog2_f(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/queue_mem.sv
// Queue storage: registered write, combinational read.
// Kept separate so it can be swapped for a BRAM wrapper.
module queue_mem
  import sync_queue_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = 1 << DEF_DEPTH_LOG2,
  localparam int AW    = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] entries [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the pointers, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (we) entries[waddr] <= wdata;
  end

  assign rdata = entries[raddr];

endmodule

// File: rtl/sync_queue.sv
// Single-clock FWFT queue with occupancy count, almost-full/empty and sticky error flags.
// Define SYNC_QUEUE_WATERMARK_EN to add the peak_count high-water-mark output.
module sync_queue
  import sync_queue_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int AFULL_LEVEL  = 3,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      wr_port,
  input  logic                  wr_req,
  output logic                  q_full,
  output logic                  q_afull,
  output logic [WIDTH-1:0]      rd_port,
  output logic                  q_empty,
  output logic                  q_aempty,
  input  logic                  rd_done,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  err_ovf,
  output logic                  err_udf
`ifdef SYNC_QUEUE_WATERMARK_EN
  ,
  output logic [DEPTH_LOG2:0]   peak_count
`endif
);

  localparam int            PW       = ptr_width(DEPTH_LOG2);
  localparam logic [PW-1:0] DEPTH_C  = PW'(1 << DEPTH_LOG2);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LEVEL);
  localparam logic [PW-1:0] ONE_C    = PW'(1);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_acc, rd_acc;

  assign q_full   = (count == DEPTH_C);
  assign q_empty  = (count == '0);
  assign q_afull  = (count >= AFULL_C);
  assign q_aempty = (count <= AEMPTY_C);

  // A read frees a slot in the same cycle, so a full queue still accepts a write alongside it.
  assign wr_acc = wr_req & (~q_full | rd_done);
  assign rd_acc = rd_done & ~q_empty;

  queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (1 << DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~reset),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (wr_port),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (rd_port)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
      if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (wr_req & q_full & ~rd_done) err_ovf <= 1'b1;
      if (rd_done & q_empty)          err_udf <= 1'b1;
    end
  end

`ifdef SYNC_QUEUE_WATERMARK_EN
  always_ff @(posedge clk) begin
    if (reset)                   peak_count <= '0;
    else if (count > peak_count) peak_count <= count;
  end
`endif

endmodule

// File: tb/tb_sync_queue.sv
// Directed self-checking bench for sync_queue with default parameters.
// Checks reset, fill/drain, full read+write, overflow/underflow, wrap-around and mid-run reset.
module tb_sync_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wr_port;
  logic        wr_req;
  logic        q_full, q_afull, q_empty, q_aempty;
  logic [15:0] rd_port;
  logic        rd_done;
  logic [2:0]  count;
  logic        err_ovf, err_udf;
`ifdef SYNC_QUEUE_WATERMARK_EN
  logic [2:0]  peak_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sync_queue dut (
    .clk      (clk),
    .reset    (reset),
    .wr_port  (wr_port),
    .wr_req   (wr_req),
    .q_full   (q_full),
    .q_afull  (q_afull),
    .rd_port  (rd_port),
    .q_empty  (q_empty),
    .q_aempty (q_aempty),
    .rd_done  (rd_done),
    .count    (count),
    .err_ovf  (err_ovf),
    .err_udf  (err_udf)
`ifdef SYNC_QUEUE_WATERMARK_EN
    ,
    .peak_count (peak_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_req  = 1'b1;
    wr_port = d;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] d);
    check(tag, {16'h0, rd_port}, {16'h0, d});
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] c);
    check({tag, "_count"},  {29'h0, count},    {29'h0, c});
    check({tag, "_empty"},  {31'h0, q_empty},  {31'h0, (c == 3'd0)});
    check({tag, "_full"},   {31'h0, q_full},   {31'h0, (c == 3'd4)});
    check({tag, "_afull"},  {31'h0, q_afull},  {31'h0, (c >= 3'd3)});
    check({tag, "_aempty"}, {31'h0, q_aempty}, {31'h0, (c <= 3'd1)});
  endtask

  initial begin
    logic [15:0] fill_data [4];
    fill_data = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    reset   = 1'b1;
    wr_req  = 1'b0;
    rd_done = 1'b0;
    wr_port = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_flags("reset", 3'd0);
    check("reset_ovf", {31'h0, err_ovf}, 32'h0);
    check("reset_udf", {31'h0, err_udf}, 32'h0);

    // Fill: head visible one cycle after the first write
    for (int i = 0; i < 4; i++) begin
      push(fill_data[i]);
      check_flags($sformatf("fill%0d", i), 3'(i + 1));
      check($sformatf("fill%0d_head", i), {16'h0, rd_port}, 32'h1111);
    end

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      pop_expect($sformatf("drain%0d_data", i), fill_data[i]);
      check_flags($sformatf("drain%0d", i), 3'(3 - i));
    end

    // Full with simultaneous read and write
    for (int i = 0; i < 4; i++) push(fill_data[i]);
    check_flags("refill", 3'd4);
    wr_req  = 1'b1;
    rd_done = 1'b1;
    wr_port = 16'h5555;
    tick();
    wr_req  = 1'b0;
    rd_done = 1'b0;
    check_flags("full_rw", 3'd4);
    check("full_rw_ovf", {31'h0, err_ovf}, 32'h0);
    pop_expect("full_rw_d0", 16'h2222);
    pop_expect("full_rw_d1", 16'h3333);
    pop_expect("full_rw_d2", 16'h4444);
    pop_expect("full_rw_d3", 16'h5555);
    check_flags("full_rw_drained", 3'd0);

    // Overflow: rejected write sets sticky flag and is never stored
    push(16'h0101);
    push(16'h0202);
    push(16'h0303);
    push(16'h0404);
    push(16'hAAAA);
    check("ovf_flag", {31'h0, err_ovf}, 32'h1);
    check_flags("ovf", 3'd4);
    pop_expect("ovf_d0", 16'h0101);
    pop_expect("ovf_d1", 16'h0202);
    pop_expect("ovf_d2", 16'h0303);
    pop_expect("ovf_d3", 16'h0404);
    check_flags("ovf_drained", 3'd0);
    check("ovf_sticky", {31'h0, err_ovf}, 32'h1);

    // Underflow on empty
    check("udf_pre", {31'h0, err_udf}, 32'h0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("udf_flag", {31'h0, err_udf}, 32'h1);
    check_flags("udf", 3'd0);

    // Simultaneous read and write on empty: write only
    wr_req  = 1'b1;
    rd_done = 1'b1;
    wr_port = 16'h7777;
    tick();
    wr_req  = 1'b0;
    rd_done = 1'b0;
    check_flags("empty_rw", 3'd1);
    pop_expect("empty_rw_data", 16'h7777);
    check_flags("empty_rw_drained", 3'd0);

    // Wrap-around across the pointer MSB
    for (int i = 1; i <= 10; i++) begin
      push(16'(i));
      check($sformatf("wrap%0d_count", i), {29'h0, count}, 32'h1);
      pop_expect($sformatf("wrap%0d_data", i), 16'(i));
      check($sformatf("wrap%0d_empty", i), {31'h0, q_empty}, 32'h1);
    end

    // Reset mid-operation together with a write
    push(16'hB001);
    push(16'hB002);
    push(16'hB003);
    check_flags("pre_rst", 3'd3);
`ifdef SYNC_QUEUE_WATERMARK_EN
    check("peak_pre_rst", {29'h0, peak_count}, 32'h4);
`endif
    reset   = 1'b1;
    wr_req  = 1'b1;
    wr_port = 16'hDEAD;
    tick();
    reset   = 1'b0;
    wr_req  = 1'b0;
    check_flags("mid_rst", 3'd0);
    check("mid_rst_ovf", {31'h0, err_ovf}, 32'h0);
    check("mid_rst_udf", {31'h0, err_udf}, 32'h0);
`ifdef SYNC_QUEUE_WATERMARK_EN
    check("peak_post_rst", {29'h0, peak_count}, 32'h0);
`endif
    tick();
    check_flags("mid_rst_settled", 3'd0);

    // Queue works normally after reset
    push(16'hC0DE);
    check_flags("post_rst", 3'd1);
    pop_expect("post_rst_data", 16'hC0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
